// File: rtl/trace_capture_if.sv
// Signal bundle between a probed machine and trace_capture: sampling controls,
// trigger setup, readout strobe and the capture status/readout results.
interface trace_capture_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TS_WIDTH = 16
);
    localparam int unsigned SelW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic                      enable;
    logic                      mode;
    logic                      arm;
    logic [CHANNELS*WIDTH-1:0] sample_in;
    logic [SelW-1:0]           trig_sel;
    logic [WIDTH-1:0]          trig_value;
    logic                      rd_en;
    logic [CHANNELS*WIDTH-1:0] rd_data;
    logic [TS_WIDTH-1:0]       rd_time;
    logic                      rd_valid;
    logic                      rd_last;
    logic [1:0]                state;
    logic [CntW-1:0]           count;
    logic                      timed_out;

    modport master (
        output enable, mode, arm, sample_in, trig_sel, trig_value, rd_en,
        input  rd_data, rd_time, rd_valid, rd_last, state, count, timed_out
    );

    modport slave (
        input  enable, mode, arm, sample_in, trig_sel, trig_value, rd_en,
        output rd_data, rd_time, rd_valid, rd_last, state, count, timed_out
    );
endinterface

// File: rtl/trace_capture.sv
// Triggered trace buffer: timestamped snapshots into a circular buffer, with post-trigger
// window, change-only sampling, watchdog, and oldest-first readout once capture is done.
module trace_capture #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 8,
    parameter int unsigned TS_WIDTH  = 16,
    parameter int unsigned TIMEOUT   = 20000
) (
    input logic            clk,
    input logic            reset,
    trace_capture_if.slave bus
);
    localparam int unsigned SW    = CHANNELS * WIDTH;
    localparam int unsigned EntW  = SW + TS_WIDTH;
    localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam int unsigned SelW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned PostW = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;
    localparam int unsigned WdW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StArmed, StPost, StDone} state_e;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d, rd_idx_q, rd_idx_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [WdW-1:0]      wd_q, wd_d;
    logic [PostW-1:0]    post_q, post_d;
    logic [SW-1:0]       last_q, last_d;
    logic                first_q, first_d;
    logic                timed_out_q, timed_out_d;
    logic [SW-1:0]       rd_data_q;
    logic [TS_WIDTH-1:0] rd_time_q;
    logic                rd_valid_q, rd_last_q;

    logic [EntW-1:0] mem [DEPTH];

    logic             capturing, take, trig_hit, wd_expire, read_ok;
    logic [WIDTH-1:0] trig_chan;

    always_comb begin
        trig_chan = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (bus.trig_sel == SelW'(k)) trig_chan = bus.sample_in[k*WIDTH +: WIDTH];
        end
    end

    assign capturing = (state_q == StArmed) || (state_q == StPost);
    assign take      = capturing && !bus.arm && bus.enable &&
                       (!bus.mode || first_q || (bus.sample_in != last_q));
    assign trig_hit  = take && (trig_chan == bus.trig_value);
    assign wd_expire = (TIMEOUT != 0) && capturing && !bus.arm &&
                       (wd_q == WdW'(TIMEOUT - 1));
    assign read_ok   = (state_q == StDone) && bus.rd_en && !bus.arm && (rd_idx_q < count_q);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_idx_d    = rd_idx_q;
        count_d     = count_q;
        ts_d        = ts_q;
        wd_d        = wd_q;
        post_d      = post_q;
        last_d      = last_q;
        first_d     = first_q;
        timed_out_d = timed_out_q;
        if (bus.arm) begin
            state_d     = StArmed;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            rd_idx_d    = '0;
            count_d     = '0;
            // The arm cycle itself is time 0, so the first capturing cycle is stamped 1.
            ts_d        = TS_WIDTH'(1);
            wd_d        = '0;
            post_d      = '0;
            first_d     = 1'b1;
            timed_out_d = 1'b0;
        end else begin
            if (capturing) begin
                wd_d = wd_q + 1'b1;
                if (ts_q != '1) ts_d = ts_q + 1'b1;
            end
            if (take) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                last_d   = bus.sample_in;
                first_d  = 1'b0;
                if (count_q != CntW'(DEPTH)) count_d = count_q + 1'b1;
            end
            unique case (state_q)
                StArmed: begin
                    if (trig_hit) begin
                        if (POST_TRIG == 0) begin
                            state_d = StDone;
                        end else begin
                            state_d = StPost;
                            post_d  = PostW'(POST_TRIG);
                        end
                    end
                end
                StPost: begin
                    if (take) begin
                        post_d = post_q - 1'b1;
                        if (post_q == PostW'(1)) state_d = StDone;
                    end
                end
                default: ;
            endcase
            if (wd_expire) begin
                state_d     = StDone;
                timed_out_d = 1'b1;
            end
            if (state_q != StDone && state_d == StDone) begin
                rd_ptr_d = wr_ptr_d - PtrW'(count_d);
                rd_idx_d = '0;
            end
            if (read_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                rd_idx_d = rd_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_idx_q    <= '0;
            count_q     <= '0;
            ts_q        <= '0;
            wd_q        <= '0;
            post_q      <= '0;
            last_q      <= '0;
            first_q     <= 1'b0;
            timed_out_q <= 1'b0;
            rd_data_q   <= '0;
            rd_time_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_idx_q    <= rd_idx_d;
            count_q     <= count_d;
            ts_q        <= ts_d;
            wd_q        <= wd_d;
            post_q      <= post_d;
            last_q      <= last_d;
            first_q     <= first_d;
            timed_out_q <= timed_out_d;
            rd_valid_q  <= read_ok;
            rd_last_q   <= read_ok && ((rd_idx_q + 1'b1) == count_q);
            if (read_ok) begin
                rd_data_q <= mem[rd_ptr_q][EntW-1:TS_WIDTH];
                rd_time_q <= mem[rd_ptr_q][TS_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && take) mem[wr_ptr_q] <= {bus.sample_in, ts_q};
    end

    assign bus.state     = state_q;
    assign bus.count     = count_q;
    assign bus.timed_out = timed_out_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_time   = rd_time_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_last   = rd_last_q;
endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture with CHANNELS=2, WIDTH=8, DEPTH=8, POST_TRIG=3, TIMEOUT=50.
module tb_trace_capture;
    logic clk;
    logic reset;
    int   checks;
    int   fails;

    trace_capture_if #(.WIDTH(8), .CHANNELS(2), .DEPTH(8), .TS_WIDTH(16)) bus ();

    trace_capture #(
        .WIDTH(8), .CHANNELS(2), .DEPTH(8), .POST_TRIG(3), .TS_WIDTH(16), .TIMEOUT(50)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        bus.arm = 1'b1;
        bus.rd_en = 1'b1;
        tick();
        tick();
        checks++; if (bus.state !== 2'd0) begin fails++; $display("FAIL rst_state: got %0d want 0", bus.state); end
        checks++; if (bus.count !== 4'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", bus.count); end
        checks++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL rst_rd_valid: got %b want 0", bus.rd_valid); end
        checks++; if (bus.timed_out !== 1'b0) begin fails++; $display("FAIL rst_timed_out: got %b want 0", bus.timed_out); end
        checks++; if (bus.rd_last !== 1'b0 || bus.rd_data !== 16'h0 || bus.rd_time !== 16'h0) begin
            fails++; $display("FAIL rst_rd_regs: last %b data %h time %0d want 0/0/0", bus.rd_last, bus.rd_data, bus.rd_time);
        end
        bus.arm   = 1'b0;
        bus.rd_en = 1'b0;
        reset     = 1'b1;
        tick();
    endtask

    // ch0 equals the number of cycles since arm; trigger on 0x0A.
    task automatic test_mode0_capture();
        int k;
        bus.mode = 1'b0; bus.enable = 1'b1; bus.trig_sel = 1'b0; bus.trig_value = 8'h0A;
        bus.sample_in = 16'h0000;
        do_arm();
        k = 0;
        while (bus.state !== 2'd3 && k < 100) begin
            k++;
            bus.sample_in = {8'h00, 8'(k)};
            tick();
        end
        checks++; if (k !== 13) begin fails++; $display("FAIL m0_done_sample: got %0d want 13", k); end
        checks++; if (bus.count !== 4'd8) begin fails++; $display("FAIL m0_count: got %0d want 8", bus.count); end
        checks++; if (bus.timed_out !== 1'b0) begin fails++; $display("FAIL m0_timed_out: got %b want 0", bus.timed_out); end
        bus.rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data[7:0] !== 8'(6 + i) || bus.rd_time !== 16'(6 + i)) begin
                fails++; $display("FAIL m0_read%0d: valid %b data %h time %0d want 1/%h/%0d", i, bus.rd_valid,
                                  bus.rd_data[7:0], bus.rd_time, 8'(6 + i), 6 + i);
            end
            checks++; if (bus.rd_last !== (i == 7)) begin
                fails++; $display("FAIL m0_last%0d: got %b want %b", i, bus.rd_last, (i == 7));
            end
        end
        tick();
        checks++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL m0_read_past_end: got %b want 0", bus.rd_valid); end
        checks++; if (bus.rd_data[7:0] !== 8'h0D) begin fails++; $display("FAIL m0_hold: got %h want 0d", bus.rd_data[7:0]); end
        bus.rd_en = 1'b0;
    endtask

    task automatic test_first_trigger();
        int k;
        bus.mode = 1'b0; bus.enable = 1'b1; bus.trig_value = 8'h0A;
        bus.sample_in = 16'h0009;
        do_arm();
        k = 0;
        while (bus.state !== 2'd3 && k < 100) begin
            bus.sample_in = {8'h00, 8'(8'h0A + k)};
            k++;
            tick();
        end
        checks++; if (k !== 4) begin fails++; $display("FAIL ft_done_sample: got %0d want 4", k); end
        checks++; if (bus.count !== 4'd4) begin fails++; $display("FAIL ft_count: got %0d want 4", bus.count); end
        bus.rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data[7:0] !== 8'(8'h0A + i) || bus.rd_time !== 16'(1 + i)
                          || bus.rd_last !== (i == 3)) begin
                fails++; $display("FAIL ft_read%0d: valid %b data %h time %0d last %b want 1/%h/%0d/%b", i, bus.rd_valid,
                                  bus.rd_data[7:0], bus.rd_time, bus.rd_last, 8'(8'h0A + i), 1 + i, (i == 3));
            end
        end
        tick();
        checks++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL ft_read_past_end: got %b want 0", bus.rd_valid); end
        bus.rd_en = 1'b0;
    endtask

    // Change-only mode: ch0 = cycles/4, so stored stamps are 1,4,8,...,48.
    task automatic test_watchdog();
        int n;
        bus.mode = 1'b1; bus.enable = 1'b1; bus.trig_value = 8'hFF;
        bus.sample_in = 16'h0000;
        do_arm();
        n = 0;
        while (bus.state !== 2'd3 && n < 200) begin
            n++;
            bus.sample_in = {8'h00, 8'(n / 4)};
            tick();
        end
        checks++; if (n !== 50) begin fails++; $display("FAIL wd_done_cycle: got %0d want 50", n); end
        checks++; if (bus.timed_out !== 1'b1) begin fails++; $display("FAIL wd_timed_out: got %b want 1", bus.timed_out); end
        checks++; if (bus.count !== 4'd8) begin fails++; $display("FAIL wd_count: got %0d want 8", bus.count); end
        bus.rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_time !== 16'(20 + 4 * i) || bus.rd_data[7:0] !== 8'(5 + i)) begin
                fails++; $display("FAIL wd_read%0d: valid %b data %h time %0d want 1/%h/%0d", i, bus.rd_valid,
                                  bus.rd_data[7:0], bus.rd_time, 8'(5 + i), 20 + 4 * i);
            end
        end
        bus.rd_en = 1'b0;
        bus.mode  = 1'b0;
    endtask

    // Enable only on odd cycles; the trigger value 0x0A appears on a disabled cycle.
    task automatic test_enable_gating();
        int n;
        bus.mode = 1'b0; bus.trig_value = 8'h0A;
        bus.sample_in = 16'h0000; bus.enable = 1'b0;
        do_arm();
        n = 0;
        while (bus.state !== 2'd3 && n < 200) begin
            n++;
            bus.sample_in = {8'h00, 8'(n)};
            bus.enable    = n[0];
            tick();
        end
        bus.enable = 1'b1;
        checks++; if (n !== 50 || bus.timed_out !== 1'b1) begin
            fails++; $display("FAIL en_no_trigger: done cycle %0d timed_out %b want 50/1", n, bus.timed_out);
        end
        checks++; if (bus.count !== 4'd8) begin fails++; $display("FAIL en_count: got %0d want 8", bus.count); end
        bus.rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data[7:0] !== 8'(35 + 2 * i) || bus.rd_time !== 16'(35 + 2 * i)) begin
                fails++; $display("FAIL en_read%0d: valid %b data %h time %0d want 1/%h/%0d", i, bus.rd_valid,
                                  bus.rd_data[7:0], bus.rd_time, 8'(35 + 2 * i), 35 + 2 * i);
            end
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset_in_post();
        int k;
        bus.mode = 1'b0; bus.enable = 1'b1; bus.trig_value = 8'h0A;
        bus.sample_in = 16'h0000;
        do_arm();
        k = 0;
        while (bus.state !== 2'd2 && k < 100) begin
            k++;
            bus.sample_in = {8'h00, 8'(k)};
            tick();
        end
        checks++; if (k !== 10) begin fails++; $display("FAIL rp_post_entry: got %0d want 10", k); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (bus.state !== 2'd0 || bus.count !== 4'd0) begin
            fails++; $display("FAIL rp_reset: state %0d count %0d want 0/0", bus.state, bus.count);
        end
        bus.rd_en = 1'b1;
        tick();
        checks++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL rp_read_idle: got %b want 0", bus.rd_valid); end
        bus.rd_en = 1'b0;
        test_mode0_capture();
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        reset  = 1'b0;
        bus.enable = 1'b0; bus.mode = 1'b0; bus.arm = 1'b0; bus.sample_in = '0;
        bus.trig_sel = 1'b0; bus.trig_value = '0; bus.rd_en = 1'b0;
        test_reset();
        test_mode0_capture();
        test_first_trigger();
        test_watchdog();
        test_enable_gating();
        test_reset_in_post();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Synthesizable, parametrised capture/trace unit that records snapshots of up to CHANNELS internal machine signals (bus, pc, state, ...) into a circular buffer.
- Each snapshot is timestamped.
- Supports a value trigger, a configurable post-trigger window, a change-only sampling mode and a watchdog timeout.
- Attaches beside machine/cpu in simulation and on hardware, and is read back oldest-first after capture completes.

Parameters:
- WIDTH, 8, bits per channel.
- CHANNELS, 4, number of sampled channels; sample word is CHANNELS*WIDTH bits, channel k at bits [k*WIDTH +: WIDTH].
- DEPTH, 16, buffer entries; power of two, ≥4.
- POST_TRIG, 8, samples stored after the trigger sample; legal range 0..DEPTH-1.
- TS_WIDTH, 16, timestamp width.
- TIMEOUT, 20000, watchdog limit in clk cycles; 0 disables the watchdog.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge).
- enable  in  1  sample qualifier; when 0, no sample is taken that cycle.
- mode  in  1  0 = sample every enabled cycle; 1 = sample only when sample_in differs from the last captured word.
- arm  in  1  one-cycle pulse that starts a new capture.
- sample_in  in  CHANNELS*WIDTH  probed signals.
- trig_sel  in  $clog2(CHANNELS) (min 1)  channel compared against trig_value.
- trig_value  in  WIDTH  trigger match value.
- rd_en  in  1  read strobe, honoured in DONE only.
- rd_data  out  CHANNELS*WIDTH  read word.
- rd_time  out  TS_WIDTH  timestamp of read word.
- rd_valid  out  1  rd_data/rd_time valid.
- rd_last  out  1  qualifies the final stored entry.
- state  out  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE.
- count  out  $clog2(DEPTH+1)  entries stored.
- timed_out  out  1  capture ended by watchdog.

Behaviour:

Reset (reset==0):
- state=IDLE; count=0; rd_valid=0; rd_last=0; timed_out=0; rd_data=0; rd_time=0.
- Write pointer, read pointer, timestamp, watchdog counter and post counter cleared.
- Reset overrides all other inputs, including mid-capture.

Timestamp:
- Clears to 0 on the arm cycle and increments every clk while ARMED/POST.
- Saturates at all-ones.
- The stored value is the timestamp of the cycle the sample was taken.

Sampling:
- A sample is taken when state is ARMED/POST, enable=1, and either mode=0, or mode=1 and (sample_in != last captured word, or it is the first sample since arm).
- Each sample writes {sample_in, timestamp} at wr_ptr, then wr_ptr increments modulo DEPTH.
- count increments and saturates at DEPTH; when full, the oldest entry is overwritten.

State machine:
- IDLE: arm → ARMED.
- ARMED: a sample whose channel trig_sel equals trig_value is stored, then:
  - POST_TRIG==0 → DONE;
  - otherwise → POST, with the post counter set to POST_TRIG.
- POST: each sample decrements the post counter; the sample that makes it reach 0 → DONE.
- DONE: holds contents until arm (restarts capture) or reset.
- arm in ARMED/POST restarts capture: count=0, pointers cleared, timed_out=0.

Trigger rules:
- Only a taken sample can trigger; a match with enable=0, or suppressed in mode 1, does not trigger.

Watchdog:
- Counts every clk in ARMED/POST, cleared on arm.
- When it reaches TIMEOUT, the state → DONE and timed_out=1 on the same edge.
- If a sample is also taken on that edge, it is stored.

Readout:
- On entry to DONE, the read pointer is set to the oldest entry: (wr_ptr - count) mod DEPTH.
- Each rd_en in DONE with unread entries remaining gives rd_valid=1 on the next cycle, with rd_data/rd_time for the next entry oldest-first.
- rd_last=1 with the entry number count.
- rd_en after all entries are read, or outside DONE, gives rd_valid=0.
- rd_data/rd_time hold their last value when rd_valid=0.
- arm and rd_en on the same cycle: arm wins, no read.

Test Plan:
All scenarios use CHANNELS=2, WIDTH=8, DEPTH=8, POST_TRIG=3, TIMEOUT=50.

1. Reset: hold reset=0 for 2 clk with arm=1 and rd_en=1 → state=0, count=0, rd_valid=0, timed_out=0.
2. Mode 0, enable=1, ch0 counts 0x00,0x01,… from the arm cycle, trig_sel=0, trig_value=0x0A:
   - DONE after the 0x0D sample, count=8;
   - 8 reads return ch0 0x06…0x0D with rd_time 6…13;
   - rd_last only on 0x0D; a 9th read gives rd_valid=0.
3. Trigger on the first sample (ch0=0x0A at arm): count=4; reads 0x0A…0x0D; rd_last on the 4th.
4. Mode 1, ch0 changes every 4 cycles, trigger never matches:
   - DONE with timed_out=1, 50 cycles after arm;
   - count=8; rd_time values strictly spaced by 4.
5. Mode 0, enable toggling 1/0: only enabled cycles are stored; a trigger value presented with enable=0 does not trigger.
6. Reset=0 asserted in POST → IDLE and count=0 next cycle; rd_en gives rd_valid=0. Re-arm then capture proceeds normally per scenario 2.
